apb_slave_endpoint: RTL and testbench
=====================================

Name: apb_slave_endpoint

Overview:
- Receive-side endpoint that sits on one slave port of apb_interconnect.
- Captures one-cycle slave_valid/slave_data pulses into a show-ahead FIFO.
- Presents the buffered words to local logic over a valid/ready pop interface.
- Registers the local broadcast-subscription request that drives this slave's src_brdcst_subscription bit; flags overflow when words arrive faster than they are popped.

Parameters:
- DATA_WIDTH, 32, width of slave_data and rd_data; equals interconnect `DATA_WIDTH.
- FIFO_DEPTH, 8, number of buffered words; power of two, >= 2.
- CNT_WIDTH, 16, width of the optional drop counter.

Ports:
- pclk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- slave_data  in  DATA_WIDTH  word from interconnect; qualified by slave_valid.
- slave_valid  in  1  single-cycle strobe, one word per asserted cycle; back-to-back cycles legal.
- brdcst_subscribe  in  1  local request to receive broadcast-channel traffic.
- src_brdcst_subscription  out  1  registered copy of brdcst_subscribe, to the interconnect.
- rd_data  out  DATA_WIDTH  head-of-FIFO word.
- rd_valid  out  1  FIFO non-empty.
- rd_ready  in  1  consumer accepts rd_data when rd_valid & rd_ready.
- level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a word was dropped.
- clr_overflow  in  1  clears overflow.
- drop_cnt  out  CNT_WIDTH  dropped-word count (present only with feature).

Behaviour:
- Reset, applied at any time including mid-transfer, empties the FIFO. Outputs after reset:
  - level=0, rd_valid=0, rd_data=0.
  - overflow=0, src_brdcst_subscription=0, drop_cnt=0.
- Push = slave_valid. Pop = rd_valid & rd_ready.
- Push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
- Push while full with no pop: the word is discarded and overflow is set on the next edge. FIFO contents and pointers are unchanged.
- Latency: a word accepted at edge N gives rd_valid=1 with that word on rd_data after edge N, provided the FIFO was empty. No interconnect backpressure exists.
- Show-ahead: rd_data is valid combinationally from storage whenever rd_valid=1. It is held stable while rd_valid & !rd_ready.
- rd_data is don't-care while rd_valid=0. Implementation drives 0 only at reset.
- Pop while empty is ignored. Level never underflows.
- Simultaneous push and pop (not empty): level unchanged. Words stay in strict arrival order.
- Simultaneous push and pop when empty: push accepted, pop ignored, level -> 1.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Full = (level == FIFO_DEPTH).
- overflow: set has priority over clr_overflow in the same cycle.
- src_brdcst_subscription <= brdcst_subscribe every cycle: one-cycle latency, no filtering.
- Broadcast and unicast words are not distinguished. Both enter the same FIFO.

Optional Feature:
- Macro: APB_SLAVE_EP_DROP_CNT_EN.
- Defined:
  - drop_cnt port exists.
  - It increments by 1 for each discarded word and saturates at all-ones.
  - It is cleared by rst or clr_overflow. Increment wins over clr_overflow in the same cycle, giving result 1.
- Undefined: drop_cnt port and its counter are absent. overflow behaviour is unchanged.

Decomposition:
- Package apb_ic_pkg holds:
  - DATA_WIDTH default.
  - A typedef apb_word_t (logic [DATA_WIDTH-1:0]).
  - A helper for level width.
- Sub-module apb_sync_fifo holds storage, pointers, level, full/empty and the show-ahead read.
- apb_slave_endpoint adds the push/pop qualification, overflow/drop logic and the subscription register.

Test Plan:
- Reset mid-fill:
  - Stimulus: push 3 words, assert rst for 1 cycle.
  - Response: level=0, rd_valid=0, overflow=0, src_brdcst_subscription=0. The next push 0xA5A5A5A5 appears on rd_data one cycle later.
- Ordering:
  - Stimulus: push 0x1,0x2,0x3 back-to-back with rd_ready=0, then rd_ready=1.
  - Response: pops yield 1,2,3 in order, level goes 3->0, then rd_valid=0.
- Overflow (DEPTH=8):
  - Stimulus: 9 consecutive pushes 0x10..0x18 with rd_ready=0.
  - Response: level=8, overflow=1, drop_cnt=1 with the feature on. The first pop returns 0x10 and 0x18 is never seen.
- Full with simultaneous push+pop:
  - Stimulus: FIFO full, push 0x99 with rd_ready=1.
  - Response: level stays 8, overflow stays 0, and 0x99 is the last word popped.
- Overflow set/clear race:
  - Stimulus: drop and clr_overflow in the same cycle.
  - Response: overflow=1, drop_cnt=1. clr_overflow alone on the next cycle gives overflow=0, drop_cnt=0.
- Subscription:
  - Stimulus: toggle brdcst_subscribe 0->1->0.
  - Response: src_brdcst_subscription follows with exactly one cycle delay.

Source files
------------

// File: rtl/apb_ic_pkg.sv
// Shared types and helpers for the APB interconnect endpoints.
package apb_ic_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  typedef logic [DATA_WIDTH-1:0] apb_word_t;

  // Occupancy counters need one extra bit to represent a completely full FIFO.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/apb_sync_fifo.sv
// Show-ahead synchronous FIFO: head word is read combinationally from storage.
module apb_sync_fifo
  import apb_ic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                          pclk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          empty,
  output logic                          full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = level_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;

  // Caller guarantees push only when not full (or popping) and pop only when not empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (push) mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;
  assign empty   = (level_q == '0);
  assign full    = (level_q == LVL_W'(DEPTH));

endmodule

// File: rtl/apb_slave_endpoint.sv
// Receive endpoint for one apb_interconnect slave port: buffers strobed words for local pop.
// Define APB_SLAVE_EP_DROP_CNT_EN to add the saturating drop_cnt output.
module apb_slave_endpoint
  import apb_ic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                               pclk,
  input  logic                               rst,
  input  logic [DATA_WIDTH-1:0]              slave_data,
  input  logic                               slave_valid,
  input  logic                               brdcst_subscribe,
  output logic                               src_brdcst_subscription,
  output logic [DATA_WIDTH-1:0]              rd_data,
  output logic                               rd_valid,
  input  logic                               rd_ready,
  output logic [level_width(FIFO_DEPTH)-1:0] level,
  output logic                               overflow,
  input  logic                               clr_overflow
`ifdef APB_SLAVE_EP_DROP_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]               drop_cnt
`endif
);

  logic fifo_empty, fifo_full;
  logic push, pop, drop;
  logic overflow_q, overflow_d;
  logic subscr_q;

  assign rd_valid = ~fifo_empty;
  assign pop      = rd_valid & rd_ready;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign push     = slave_valid & (~fifo_full | pop);
  assign drop     = slave_valid & fifo_full & ~pop;

  apb_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .pclk    (pclk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (slave_data),
    .rd_data (rd_data),
    .level   (level),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_comb begin
    overflow_d = overflow_q;
    if (drop)              overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      subscr_q   <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      subscr_q   <= brdcst_subscribe;
    end
  end

  assign overflow                = overflow_q;
  assign src_brdcst_subscription = subscr_q;

`ifdef APB_SLAVE_EP_DROP_CNT_EN
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  // A drop coinciding with a clear restarts the count at one.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      if (clr_overflow)            drop_cnt_d = CNT_WIDTH'(1);
      else if (drop_cnt_q != '1)   drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
    end else if (clr_overflow) begin
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  logic [CNT_WIDTH-1:0] unused_cnt_width;
  assign unused_cnt_width = '0;
`endif

endmodule

// File: tb/tb_apb_slave_endpoint.sv
// Self-checking bench for apb_slave_endpoint against a queue-based reference model.
module tb_apb_slave_endpoint;
  import apb_ic_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 16;

  logic             pclk = 1'b0;
  logic             rst;
  apb_word_t        slave_data;
  logic             slave_valid;
  logic             brdcst_subscribe;
  logic             src_brdcst_subscription;
  apb_word_t        rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [3:0]       level;
  logic             overflow;
  logic             clr_overflow;
  logic [CNT_W-1:0] drop_cnt;

  always #5 pclk = ~pclk;

  apb_slave_endpoint #(
    .DATA_WIDTH (32),
    .FIFO_DEPTH (DEPTH),
    .CNT_WIDTH  (CNT_W)
  ) dut (
    .pclk                    (pclk),
    .rst                     (rst),
    .slave_data              (slave_data),
    .slave_valid             (slave_valid),
    .brdcst_subscribe        (brdcst_subscribe),
    .src_brdcst_subscription (src_brdcst_subscription),
    .rd_data                 (rd_data),
    .rd_valid                (rd_valid),
    .rd_ready                (rd_ready),
    .level                   (level),
    .overflow                (overflow),
    .clr_overflow            (clr_overflow)
`ifdef APB_SLAVE_EP_DROP_CNT_EN
    ,
    .drop_cnt                (drop_cnt)
`endif
  );

`ifndef APB_SLAVE_EP_DROP_CNT_EN
  assign drop_cnt = '0;
`endif

  // Reference model state
  apb_word_t        q[$];
  logic             m_ovf;
  logic             m_sub;
  int unsigned      m_dcnt;
  bit               m_after_rst;

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock cycle: apply inputs, advance the model, then compare after the edge.
  task automatic step(input logic v, input apb_word_t d, input logic rdy,
                      input logic sub, input logic clr, input logic r);
    bit popped, full;
    slave_valid      = v;
    slave_data       = d;
    rd_ready         = rdy;
    brdcst_subscribe = sub;
    clr_overflow     = clr;
    rst              = r;
    if (r) begin
      q.delete();
      m_ovf  = 1'b0;
      m_sub  = 1'b0;
      m_dcnt = 0;
    end else begin
      popped = rdy && (q.size() > 0);
      full   = (q.size() == DEPTH);
      if (popped) void'(q.pop_front());
      if (v && full && !popped) begin
        m_ovf = 1'b1;
        if (clr) m_dcnt = 1;
        else if (m_dcnt < (1 << CNT_W) - 1) m_dcnt = m_dcnt + 1;
      end else begin
        if (v) q.push_back(d);
        if (clr) begin
          m_ovf  = 1'b0;
          m_dcnt = 0;
        end
      end
      m_sub = sub;
    end
    m_after_rst = r;
    @(posedge pclk);
    #1;
    check("level", 32'(level), q.size());
    check("rd_valid", 32'(rd_valid), 32'(q.size() > 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("subscription", 32'(src_brdcst_subscription), 32'(m_sub));
    if (q.size() > 0) check("rd_data", rd_data, q[0]);
    else if (m_after_rst) check("rd_data_rst", rd_data, 32'h0);
`ifdef APB_SLAVE_EP_DROP_CNT_EN
    check("drop_cnt", 32'(drop_cnt), m_dcnt);
`endif
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, rdy, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-fill, with subscription active so its reset is visible
    for (int i = 0; i < 3; i++) step(1'b1, 32'hC0 + i, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0, 1'b0);
    check("latency_a5", rd_data, 32'hA5A5_A5A5);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Ordering
    for (int i = 1; i <= 3; i++) step(1'b1, i, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);
    check("drained_valid", 32'(rd_valid), 32'h0);

    // Overflow: nine pushes into an eight-deep FIFO
    for (int i = 0; i < 9; i++) step(1'b1, 32'h10 + i, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovf_level", 32'(level), 32'd8);
    check("ovf_flag", 32'(overflow), 32'h1);
    check("ovf_head", rd_data, 32'h10);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Full with simultaneous push and pop
    step(1'b1, 32'h99, 1'b1, 1'b0, 1'b0, 1'b0);
    check("fullpp_level", 32'(level), 32'd8);
    check("fullpp_ovf", 32'(overflow), 32'h0);
    for (int i = 0; i < 7; i++) idle(1'b1);
    check("fullpp_last", rd_data, 32'h99);
    idle(1'b1);

    // Set/clear race on overflow
    for (int i = 0; i < 8; i++) step(1'b1, 32'h200 + i, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b1, 1'b0);
    check("race_set", 32'(overflow), 32'h1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("race_clr", 32'(overflow), 32'h0);
    for (int i = 0; i < 8; i++) idle(1'b1);

    // Subscription toggle
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("sub_rise", 32'(src_brdcst_subscription), 32'h1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sub_fall", 32'(src_brdcst_subscription), 32'h0);

    // Randomized traffic with occasional clears and resets
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 60), apb_word_t'($urandom),
           1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 99) == 0));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
